// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose : bundles the controller's instruction-register inputs, ALU flag and datapath controls.
// Latency : n/a (wiring only).
// Backpressure: none; the controller advances one state per clock unconditionally.
// Ports (master = controller): opcode/funct/zero in; alu_op, alu_src_a/b, ext_zero, iord,
//   mem_read/write/byte, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
//   halted, state_dbg out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero,
        output alu_op, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write,
               mem_byte, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               halted, state_dbg
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_op, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write,
               mem_byte, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               halted, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : multi-cycle MIPS control FSM driving datapath selects, memory strobes and ALU op.
// Latency : lw/lb 5, sw/sb 4, R-type 4, I-type 4, beq 3, j 3 cycles per instruction.
// Backpressure: none; one state per clock, HALT is sticky until rst.
// Ports: clk, rst (sync, active-high); bus = mips_multicycle_ctrl_if.master (opcode/funct/zero
//   in, all datapath controls and halted/state_dbg out).
module mips_multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_multicycle_ctrl_if.master     bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MADDR  = 4'd2,  S_MREAD  = 4'd3,
        S_MWB    = 4'd4,  S_MWRITE = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, fn_q;

    logic [3:0] alu_op_c;
    logic       alu_src_a_c, ext_zero_c, iord_c, mem_read_c, mem_write_c, mem_byte_c;
    logic       ir_write_c, pc_write_c, reg_write_c, reg_dst_c, mem_to_reg_c, halted_c;
    logic [1:0] alu_src_b_c, pc_src_c;

    // Instruction fields are latched on leaving DECODE so later IR changes cannot
    // disturb an instruction already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        alu_op_c     = 4'd0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'd0;
        ext_zero_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_byte_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'd0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        halted_c     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                ir_write_c  = 1'b1;
                pc_write_c  = 1'b1;
                alu_src_b_c = 2'd1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b_c = 2'd3;
                // Decode uses the live IR; it is latched on this same edge.
                case (bus.opcode)
                    6'h23, 6'h20, 6'h2B, 6'h28: state_d = S_MADDR;
                    6'h00: begin
                        if (bus.funct == 6'h20 || bus.funct == 6'h24 || bus.funct == 6'h25)
                            state_d = S_REXEC;
                        else
                            state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                    6'h08, 6'h0C, 6'h0D: state_d = S_IEXEC;
                    6'h04:               state_d = S_BRANCH;
                    6'h02:               state_d = S_JUMP;
                    default:             state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                state_d     = (op_q == 6'h2B || op_q == 6'h28) ? S_MWRITE : S_MREAD;
            end
            S_MREAD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                mem_byte_c = (op_q == 6'h20);
                state_d    = S_MWB;
            end
            S_MWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MWRITE: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                mem_byte_c  = (op_q == 6'h28);
            end
            S_REXEC: begin
                alu_src_a_c = 1'b1;
                case (fn_q)
                    6'h24:   alu_op_c = 4'd1;
                    6'h25:   alu_op_c = 4'd2;
                    default: alu_op_c = 4'd0;
                endcase
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                case (op_q)
                    6'h0C:   begin alu_op_c = 4'd1; ext_zero_c = 1'b1; end
                    6'h0D:   begin alu_op_c = 4'd2; ext_zero_c = 1'b1; end
                    default: alu_op_c = 4'd0;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                // EQ-compare yields 1 on equal, so a zero flag of 0 means taken.
                alu_src_a_c = 1'b1;
                alu_op_c    = 4'd3;
                pc_src_c    = 2'd1;
                pc_write_c  = ~bus.zero;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'd2;
            end
            S_HALT: begin
                halted_c = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low combinationally while rst is high so that a reset
    // landing mid-instruction never lets a write strobe through.
    assign bus.alu_op     = rst ? 4'd0 : alu_op_c;
    assign bus.alu_src_a  = ~rst & alu_src_a_c;
    assign bus.alu_src_b  = rst ? 2'd0 : alu_src_b_c;
    assign bus.ext_zero   = ~rst & ext_zero_c;
    assign bus.iord       = ~rst & iord_c;
    assign bus.mem_read   = ~rst & mem_read_c;
    assign bus.mem_write  = ~rst & mem_write_c;
    assign bus.mem_byte   = ~rst & mem_byte_c;
    assign bus.ir_write   = ~rst & ir_write_c;
    assign bus.pc_write   = ~rst & pc_write_c;
    assign bus.pc_src     = rst ? 2'd0 : pc_src_c;
    assign bus.reg_write  = ~rst & reg_write_c;
    assign bus.reg_dst    = ~rst & reg_dst_c;
    assign bus.mem_to_reg = ~rst & mem_to_reg_c;
    assign bus.halted     = ~rst & halted_c;
    assign bus.state_dbg  = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : directed stimulus for mips_multicycle_ctrl with a queue-based output scoreboard.
// Latency : one expected output vector per clock, compared mid-cycle.
// Backpressure: none.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
        logic [3:0] state_dbg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Hand-written expected output vectors per state.
    function automatic exp_t e_zero();
        exp_t e = '0; return e;
    endfunction
    function automatic exp_t e_fetch();
        exp_t e = '0;
        e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'd1;
        e.state_dbg = 4'd0; return e;
    endfunction
    function automatic exp_t e_decode();
        exp_t e = '0; e.alu_src_b = 2'd3; e.state_dbg = 4'd1; return e;
    endfunction
    function automatic exp_t e_maddr();
        exp_t e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.state_dbg = 4'd2; return e;
    endfunction
    function automatic exp_t e_mread(input logic b);
        exp_t e = '0; e.mem_read = 1'b1; e.iord = 1'b1; e.mem_byte = b; e.state_dbg = 4'd3; return e;
    endfunction
    function automatic exp_t e_mwb();
        exp_t e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.state_dbg = 4'd4; return e;
    endfunction
    function automatic exp_t e_mwrite(input logic b);
        exp_t e = '0; e.mem_write = 1'b1; e.iord = 1'b1; e.mem_byte = b; e.state_dbg = 4'd5; return e;
    endfunction
    function automatic exp_t e_rexec(input logic [3:0] op);
        exp_t e = '0; e.alu_src_a = 1'b1; e.alu_op = op; e.state_dbg = 4'd6; return e;
    endfunction
    function automatic exp_t e_rwb();
        exp_t e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.state_dbg = 4'd7; return e;
    endfunction
    function automatic exp_t e_iexec(input logic [3:0] op, input logic ez);
        exp_t e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = op; e.ext_zero = ez;
        e.state_dbg = 4'd8; return e;
    endfunction
    function automatic exp_t e_iwb();
        exp_t e = '0; e.reg_write = 1'b1; e.state_dbg = 4'd9; return e;
    endfunction
    function automatic exp_t e_branch(input logic pcw);
        exp_t e = '0; e.alu_src_a = 1'b1; e.alu_op = 4'd3; e.pc_src = 2'd1; e.pc_write = pcw;
        e.state_dbg = 4'd10; return e;
    endfunction
    function automatic exp_t e_jump();
        exp_t e = '0; e.pc_write = 1'b1; e.pc_src = 2'd2; e.state_dbg = 4'd11; return e;
    endfunction
    function automatic exp_t e_halt();
        exp_t e = '0; e.halted = 1'b1; e.state_dbg = 4'd15; return e;
    endfunction

    // One clock of stimulus: drive inputs just after the edge and queue what the
    // outputs must look like during that cycle.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst        = r;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Decode cycle drives the real opcode; all later cycles drive a different one
    // so a controller that fails to latch the IR is caught.
    task automatic run_load(input logic [5:0] op, input logic [5:0] junk, input logic b);
        cyc(0, junk, 6'h00, 1'b0, e_fetch(),   "ld_fetch");
        cyc(0, op,   6'h00, 1'b0, e_decode(),  "ld_decode");
        cyc(0, junk, 6'h00, 1'b0, e_maddr(),   "ld_maddr");
        cyc(0, junk, 6'h00, 1'b1, e_mread(b),  "ld_mread");
        cyc(0, junk, 6'h00, 1'b0, e_mwb(),     "ld_mwb");
    endtask

    task automatic run_store(input logic [5:0] op, input logic [5:0] junk, input logic b);
        cyc(0, junk, 6'h00, 1'b0, e_fetch(),   "st_fetch");
        cyc(0, op,   6'h00, 1'b0, e_decode(),  "st_decode");
        cyc(0, junk, 6'h00, 1'b0, e_maddr(),   "st_maddr");
        cyc(0, junk, 6'h00, 1'b0, e_mwrite(b), "st_mwrite");
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [3:0] op);
        cyc(0, 6'h23, 6'h25, 1'b0, e_fetch(),    "r_fetch");
        cyc(0, 6'h00, fn,    1'b0, e_decode(),   "r_decode");
        cyc(0, 6'h2B, 6'h3F, 1'b0, e_rexec(op),  "r_exec");
        cyc(0, 6'h2B, 6'h3F, 1'b0, e_rwb(),      "r_wb");
    endtask

    task automatic run_i(input logic [5:0] opc, input logic [3:0] op, input logic ez);
        cyc(0, 6'h00, 6'h00, 1'b0, e_fetch(),       "i_fetch");
        cyc(0, opc,   6'h00, 1'b0, e_decode(),      "i_decode");
        cyc(0, 6'h04, 6'h00, 1'b0, e_iexec(op, ez), "i_exec");
        cyc(0, 6'h04, 6'h00, 1'b0, e_iwb(),         "i_wb");
    endtask

    task automatic run_beq(input logic z);
        cyc(0, 6'h00, 6'h00, 1'b1, e_fetch(),     "beq_fetch");
        cyc(0, 6'h04, 6'h00, 1'b1, e_decode(),    "beq_decode");
        cyc(0, 6'h02, 6'h00, z,    e_branch(~z),  "beq_branch");
    endtask

    task automatic run_j();
        cyc(0, 6'h00, 6'h00, 1'b0, e_fetch(),  "j_fetch");
        cyc(0, 6'h02, 6'h00, 1'b0, e_decode(), "j_decode");
        cyc(0, 6'h23, 6'h00, 1'b0, e_jump(),   "j_jump");
    endtask

    // Monitor: compares the full output vector in the middle of each queued cycle.
    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{alu_op: bus.alu_op, alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b,
                        ext_zero: bus.ext_zero, iord: bus.iord, mem_read: bus.mem_read,
                        mem_write: bus.mem_write, mem_byte: bus.mem_byte, ir_write: bus.ir_write,
                        pc_write: bus.pc_write, pc_src: bus.pc_src, reg_write: bus.reg_write,
                        reg_dst: bus.reg_dst, mem_to_reg: bus.mem_to_reg, halted: bus.halted,
                        state_dbg: bus.state_dbg};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                             nm, act, e, act.state_dbg, e.state_dbg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        bus.opcode = 6'h3F;
        bus.funct  = 6'h3F;
        bus.zero   = 1'b0;

        // Two reset cycles, everything low even though the state register is unknown.
        cyc(1, 6'h2B, 6'h00, 1'b0, e_zero(), "reset0");
        cyc(1, 6'h2B, 6'h00, 1'b0, e_zero(), "reset1");

        run_load(6'h23, 6'h20, 1'b0);   // lw
        run_load(6'h20, 6'h23, 1'b1);   // lb
        run_store(6'h2B, 6'h28, 1'b0);  // sw
        run_store(6'h28, 6'h2B, 1'b1);  // sb
        run_r(6'h20, 4'd0);             // add
        run_r(6'h24, 4'd1);             // and
        run_r(6'h25, 4'd2);             // or
        run_i(6'h08, 4'd0, 1'b0);       // addi
        run_i(6'h0C, 4'd1, 1'b1);       // andi
        run_i(6'h0D, 4'd2, 1'b1);       // ori
        run_beq(1'b0);                  // taken
        run_beq(1'b1);                  // not taken
        run_j();

        // Reset landing in MWRITE: no write strobe that cycle, FETCH next.
        cyc(0, 6'h00, 6'h00, 1'b0, e_fetch(),  "rw_fetch");
        cyc(0, 6'h2B, 6'h00, 1'b0, e_decode(), "rw_decode");
        cyc(0, 6'h2B, 6'h00, 1'b0, e_maddr(),  "rw_maddr");
        cyc(1, 6'h2B, 6'h00, 1'b0, e_zero(),   "rw_reset");
        run_store(6'h28, 6'h23, 1'b1);

        // Unsupported R-type funct halts.
        cyc(0, 6'h00, 6'h00, 1'b0, e_fetch(),  "badfn_fetch");
        cyc(0, 6'h00, 6'h22, 1'b0, e_decode(), "badfn_decode");
        cyc(0, 6'h23, 6'h20, 1'b0, e_halt(),   "badfn_halt");
        cyc(1, 6'h00, 6'h00, 1'b0, e_zero(),   "badfn_reset");

        // Illegal opcode: sticky HALT for 20 cycles regardless of inputs.
        cyc(0, 6'h00, 6'h00, 1'b0, e_fetch(),  "ill_fetch");
        cyc(0, 6'h3F, 6'h00, 1'b0, e_decode(), "ill_decode");
        for (int i = 0; i < 20; i++) begin
            logic [5:0] ops [4];
            ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h04; ops[3] = 6'h02;
            cyc(0, ops[i % 4], 6'h20, i[0], e_halt(), "ill_halt");
        end
        cyc(1, 6'h3F, 6'h00, 1'b0, e_zero(), "ill_reset");
        run_j();

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
